// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, pending-PC tracking, small instruction queue.
// Optional FETCH_PERF_COUNTERS_EN adds saturating bubble and flush counters.
module fetch_unit #(
    parameter int unsigned         XLEN        = 64,
    parameter logic [XLEN-1:0]     RESET_PC    = '0,
    parameter int unsigned         QUEUE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            inst_valid_out,
    output logic [XLEN-1:0] current_pc_out,
    output logic [31:0]     current_inst_out,
    output logic            fetch_fault_out
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]     bubble_count_out,
    output logic [31:0]     flush_count_out
`endif
);

    localparam int unsigned     PW      = $clog2(QUEUE_DEPTH);
    localparam int unsigned     CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_L = (CW + 1)'(QUEUE_DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET_IDLE,
        RUN,
        FAULT_HOLD
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_hold_q, pc_hold_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [PW-1:0]   pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;

    logic [XLEN-1:0] q_pc_q   [QUEUE_DEPTH];
    logic [31:0]     q_inst_q [QUEUE_DEPTH];
    logic            q_err_q  [QUEUE_DEPTH];
    logic [XLEN-1:0] pend_pc_q[QUEUE_DEPTH];

    logic            accept, push, pop, drop, head_valid, room;
    logic [XLEN-1:0] rsp_pc;
    logic            redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RESET_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every signal written in always_comb gets a default first, so no latch can form.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_IDLE: state_d = RUN;
            RUN:        if (push && imem_rsp_err) state_d = FAULT_HOLD;
            FAULT_HOLD: state_d = FAULT_HOLD;
            default:    state_d = RESET_IDLE;
        endcase
        if (redirect_valid) state_d = RUN;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        room           = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_L;
        imem_req_valid = (state_q == RUN) && !redirect_valid && room;
    end

    assign imem_req_addr = fetch_pc_q;

    // ---------------- Head presentation ----------------
    assign head_valid       = (count_q != '0);
    assign inst_valid_out   = head_valid;
    assign current_pc_out   = head_valid ? q_pc_q[q_rd_q] : pc_hold_q;
    assign current_inst_out = head_valid ? q_inst_q[q_rd_q] : NOP;
    assign fetch_fault_out  = head_valid && q_err_q[q_rd_q];

    // ---------------- Datapath next state ----------------
    always_comb begin
        accept = imem_req_valid && imem_req_ready;
        drop   = imem_rsp_valid && (discard_q != '0);
        push   = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
        pop    = head_valid && !stall && !redirect_valid;
        // A response with nothing pending belongs to the request accepted this very cycle.
        rsp_pc = (outstanding_q == '0) ? fetch_pc_q : pend_pc_q[pend_rd_q];

        fetch_pc_d    = fetch_pc_q;
        pend_wr_d     = pend_wr_q;
        pend_rd_d     = pend_rd_q;
        discard_d     = discard_q;
        q_wr_d        = q_wr_q;
        q_rd_d        = q_rd_q;
        pc_hold_d     = current_pc_out;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
        count_d       = count_q + CW'(push) - CW'(pop);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            pend_wr_d  = pend_wr_q + PW'(1);
        end
        if (imem_rsp_valid) pend_rd_d = pend_rd_q + PW'(1);
        if (drop)           discard_d = discard_q - CW'(1);
        if (push)           q_wr_d    = q_wr_q + PW'(1);
        if (pop)            q_rd_d    = q_rd_q + PW'(1);

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            count_d    = '0;
            q_wr_d     = q_rd_q;
            q_rd_d     = q_rd_q;
            discard_d  = outstanding_q - CW'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            pc_hold_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            q_rd_q        <= '0;
            q_wr_q        <= '0;
            pend_rd_q     <= '0;
            pend_wr_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            pc_hold_q     <= pc_hold_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            q_rd_q        <= q_rd_d;
            q_wr_q        <= q_wr_d;
            pend_rd_q     <= pend_rd_d;
            pend_wr_q     <= pend_wr_d;
        end
    end

    // NOTE: storage arrays are not reset; an entry is only read once its count/pointer marks it valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[q_wr_q]   <= rsp_pc;
            q_inst_q[q_wr_q] <= imem_rsp_data;
            q_err_q[q_wr_q]  <= imem_rsp_err;
        end
        if (accept) pend_pc_q[pend_wr_q] <= fetch_pc_q;
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] bubble_count_q, bubble_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        bubble_count_d = bubble_count_q;
        flush_count_d  = flush_count_q;
        if (!head_valid && !stall && (state_q == RUN) && (bubble_count_q != 32'hFFFF_FFFF))
            bubble_count_d = bubble_count_q + 32'd1;
        if (redirect_valid && (flush_count_q != 32'hFFFF_FFFF))
            flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bubble_count_out = bubble_count_q;
    assign flush_count_out  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, fault, async reset and PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        man_rsp_valid = 1'b0;
    logic [31:0] man_rsp_data = '0;
    logic        man_rsp_err = 1'b0;
    logic        comb_mode = 1'b1;
    logic        tag_data = 1'b0;
    logic [63:0] err_addr = 64'h1;

    logic        imem_req_valid, imem_rsp_valid, imem_rsp_err;
    logic [63:0] imem_req_addr, current_pc_out;
    logic [31:0] imem_rsp_data, current_inst_out;
    logic        inst_valid_out, fetch_fault_out;

    logic        w_req_valid, w_inst_valid;
    logic [63:0] w_req_addr, w_pc;
    logic [31:0] w_inst_unused;
    logic        w_fault_unused;

    int errors = 0;
    int checks = 0;

    // Memory model: zero-latency (response in the acceptance cycle) or bench-driven.
    assign imem_rsp_valid = comb_mode ? (imem_req_valid && imem_req_ready) : man_rsp_valid;
    assign imem_rsp_data  = comb_mode ? (tag_data ? {8'hA5, imem_req_addr[23:0]} : 32'h0000_0013) : man_rsp_data;
    assign imem_rsp_err   = comb_mode ? (imem_req_addr == err_addr) : man_rsp_err;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] bubble_count_out, flush_count_out, w_bubble_unused, w_flush_unused;
`endif

    fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid_out(inst_valid_out), .current_pc_out(current_pc_out),
        .current_inst_out(current_inst_out), .fetch_fault_out(fetch_fault_out)
`ifdef FETCH_PERF_COUNTERS_EN
        , .bubble_count_out(bubble_count_out), .flush_count_out(flush_count_out)
`endif
    );

    fetch_unit #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .QUEUE_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_req_valid && imem_req_ready), .imem_rsp_data(32'h0000_0013), .imem_rsp_err(1'b0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid_out(w_inst_valid), .current_pc_out(w_pc),
        .current_inst_out(w_inst_unused), .fetch_fault_out(w_fault_unused)
`ifdef FETCH_PERF_COUNTERS_EN
        , .bubble_count_out(w_bubble_unused), .flush_count_out(w_flush_unused)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    // Leaves rst released just after a negedge; the next posedge moves RESET_IDLE -> RUN.
    task automatic do_reset;
        rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0; man_rsp_valid = 1'b0; man_rsp_err = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
            checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
            checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %0b want 0", inst_valid_out); end
            checks++; if (current_pc_out !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", current_pc_out); end
            checks++; if (current_inst_out !== 32'h13) begin errors++; $display("FAIL rst_inst: got %h want 00000013", current_inst_out); end
            checks++; if (fetch_fault_out !== 1'b0) begin errors++; $display("FAIL rst_fault: got %0b want 0", fetch_fault_out); end
        end
    endtask

    task automatic test_stream;
        comb_mode = 1'b1; tag_data = 1'b0;
        do_reset();
        tick(); #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stream_first_req: got %0b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL stream_first_addr: got %h want 0", imem_req_addr); end
        checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL stream_not_yet_valid: got %0b want 0", inst_valid_out); end
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            checks++; if (inst_valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, inst_valid_out); end
            checks++; if (current_pc_out !== 64'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, current_pc_out, 64'(4 * i)); end
            checks++; if (current_inst_out !== 32'h13) begin errors++; $display("FAIL stream_inst[%0d]: got %h want 00000013", i, current_inst_out); end
        end
    endtask

    task automatic test_stall;
        comb_mode = 1'b1; tag_data = 1'b1;
        do_reset();
        repeat (6) tick();
        #1;
        checks++; if (current_pc_out !== 64'h10) begin errors++; $display("FAIL stall_setup_pc: got %h want 10", current_pc_out); end
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(); #1;
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid[%0d]: got %0b want 0", c, imem_req_valid); end
            checks++; if (current_pc_out !== 64'h10 || inst_valid_out !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got pc %h valid %0b want pc 10 valid 1", c, current_pc_out, inst_valid_out); end
        end
        stall = 1'b0;
        tick(); #1;
        checks++; if (current_pc_out !== 64'h14) begin errors++; $display("FAIL stall_release_pc0: got %h want 14", current_pc_out); end
        checks++; if (current_inst_out !== 32'hA500_0014) begin errors++; $display("FAIL stall_release_inst: got %h want a5000014", current_inst_out); end
        tick(); #1;
        checks++; if (current_pc_out !== 64'h18) begin errors++; $display("FAIL stall_release_pc1: got %h want 18", current_pc_out); end
    endtask

    task automatic test_redirect;
        comb_mode = 1'b0;
        do_reset();
        tick(); redirect_valid = 1'b1; redirect_pc = 64'h20;
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h20) begin errors++; $display("FAIL redir_req20: got v%0b %h want v1 20", imem_req_valid, imem_req_addr); end
        tick(); #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h24) begin errors++; $display("FAIL redir_req24: got v%0b %h want v1 24", imem_req_valid, imem_req_addr); end
        tick(); #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_two_outstanding: got %0b want 0", imem_req_valid); end
        man_rsp_valid = 1'b1; man_rsp_data = 32'hDEAD_0020; redirect_valid = 1'b1; redirect_pc = 64'h103; #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle_req: got %0b want 0", imem_req_valid); end
        tick(); redirect_valid = 1'b0; man_rsp_data = 32'hDEAD_0024; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) begin errors++; $display("FAIL redir_req100: got v%0b %h want v1 100", imem_req_valid, imem_req_addr); end
        checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL redir_flushed: got %0b want 0", inst_valid_out); end
        tick(); man_rsp_data = 32'h1111_0100; #1;
        checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL redir_stale_dropped: got %0b want 0", inst_valid_out); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h104) begin errors++; $display("FAIL redir_req104: got v%0b %h want v1 104", imem_req_valid, imem_req_addr); end
        tick(); man_rsp_valid = 1'b0; #1;
        checks++; if (inst_valid_out !== 1'b1 || current_pc_out !== 64'h100) begin errors++; $display("FAIL redir_first_pc: got v%0b %h want v1 100", inst_valid_out, current_pc_out); end
        checks++; if (current_inst_out !== 32'h1111_0100) begin errors++; $display("FAIL redir_first_inst: got %h want 11110100", current_inst_out); end
    endtask

    task automatic test_fault;
        comb_mode = 1'b1; tag_data = 1'b1; err_addr = 64'h40;
        do_reset();
        tick(); redirect_valid = 1'b1; redirect_pc = 64'h40;
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h40) begin errors++; $display("FAIL fault_req40: got v%0b %h want v1 40", imem_req_valid, imem_req_addr); end
        tick(); #1;
        checks++; if (inst_valid_out !== 1'b1 || current_pc_out !== 64'h40) begin errors++; $display("FAIL fault_head: got v%0b %h want v1 40", inst_valid_out, current_pc_out); end
        checks++; if (fetch_fault_out !== 1'b1) begin errors++; $display("FAIL fault_flag: got %0b want 1", fetch_fault_out); end
        checks++; if (current_inst_out !== 32'hA500_0040) begin errors++; $display("FAIL fault_inst: got %h want a5000040", current_inst_out); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fault_hold_req0: got %0b want 0", imem_req_valid); end
        tick(); #1;
        checks++; if (inst_valid_out !== 1'b0 || fetch_fault_out !== 1'b0) begin errors++; $display("FAIL fault_drained: got v%0b f%0b want v0 f0", inst_valid_out, fetch_fault_out); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fault_hold_req1: got %0b want 0", imem_req_valid); end
        tick(); #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fault_hold_req2: got %0b want 0", imem_req_valid); end
        redirect_valid = 1'b1; redirect_pc = 64'h80;
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80) begin errors++; $display("FAIL fault_resume_req: got v%0b %h want v1 80", imem_req_valid, imem_req_addr); end
        tick(); #1;
        checks++; if (inst_valid_out !== 1'b1 || current_pc_out !== 64'h80 || fetch_fault_out !== 1'b0) begin errors++; $display("FAIL fault_resume_head: got v%0b %h f%0b want v1 80 f0", inst_valid_out, current_pc_out, fetch_fault_out); end
        err_addr = 64'h1;
    endtask

    task automatic test_reset_midflight;
        comb_mode = 1'b0; tag_data = 1'b1;
        do_reset();
        tick(); redirect_valid = 1'b1; redirect_pc = 64'h200;
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (imem_req_addr !== 64'h200) begin errors++; $display("FAIL mid_req200: got %h want 200", imem_req_addr); end
        tick(); #1;
        checks++; if (imem_req_addr !== 64'h204) begin errors++; $display("FAIL mid_req204: got %h want 204", imem_req_addr); end
        tick(); #1;
        checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h208) begin errors++; $display("FAIL mid_full: got v%0b %h want v0 208", imem_req_valid, imem_req_addr); end
        #1 rst = 1'b0;
        #1;
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL mid_async_addr: got %h want 0", imem_req_addr); end
        checks++; if (imem_req_valid !== 1'b0 || inst_valid_out !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got req %0b inst %0b want 0 0", imem_req_valid, inst_valid_out); end
        checks++; if (current_pc_out !== 64'h0 || current_inst_out !== 32'h13 || fetch_fault_out !== 1'b0) begin errors++; $display("FAIL mid_async_head: got %h %h %0b want 0 00000013 0", current_pc_out, current_inst_out, fetch_fault_out); end
        comb_mode = 1'b1;
        do_reset();
        tick(); #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0 || inst_valid_out !== 1'b0) begin errors++; $display("FAIL mid_restart_req: got v%0b %h inst %0b want v1 0 inst 0", imem_req_valid, imem_req_addr, inst_valid_out); end
        tick(); #1;
        checks++; if (inst_valid_out !== 1'b1 || current_pc_out !== 64'h0 || current_inst_out !== 32'hA500_0000) begin errors++; $display("FAIL mid_restart_head: got v%0b %h %h want v1 0 a5000000", inst_valid_out, current_pc_out, current_inst_out); end
    endtask

    task automatic test_wrap;
        comb_mode = 1'b1;
        do_reset();
        tick(); #1;
        checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_first: got v%0b %h want v1 fffffffffffffffc", w_req_valid, w_req_addr); end
        tick(); #1;
        checks++; if (w_req_addr !== 64'h0) begin errors++; $display("FAIL wrap_next_addr: got %h want 0", w_req_addr); end
        checks++; if (w_inst_valid !== 1'b1 || w_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_head: got v%0b %h want v1 fffffffffffffffc", w_inst_valid, w_pc); end
        tick(); #1;
        checks++; if (w_pc !== 64'h0) begin errors++; $display("FAIL wrap_head_next: got %h want 0", w_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fault();
        test_reset_midflight();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

endmodule
